// File: rtl/irrigation_pkg.sv
// Shared types for the irrigation scheduler: FSM states, BCD digit type, state codes.
// Pure declarations, no logic.
package irrigation_pkg;

    localparam logic [2:0] CODE_IDLE     = 3'd0;
    localparam logic [2:0] CODE_SETTLE   = 3'd1;
    localparam logic [2:0] CODE_IRRIGATE = 3'd2;
    localparam logic [2:0] CODE_REFILL   = 3'd3;
    localparam logic [2:0] CODE_FAULT    = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE     = CODE_IDLE,
        ST_SETTLE   = CODE_SETTLE,
        ST_IRRIGATE = CODE_IRRIGATE,
        ST_REFILL   = CODE_REFILL,
        ST_FAULT    = CODE_FAULT
    } state_t;

    typedef logic [3:0] bcd_t;

endpackage

// File: rtl/bcd_countdown.sv
// mm:ss BCD countdown: load/clear/decrement take effect on the next edge; clear > load > dec.
// Decrement is ignored at 00:00, so the count never underflows.
module bcd_countdown
    import irrigation_pkg::*;
#(
    parameter int MINUTES = 30
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  logic clear,
    input  logic dec,
    output bcd_t minutes_d,
    output bcd_t minutes_u,
    output bcd_t seconds_d,
    output bcd_t seconds_u,
    output logic zero
);

    localparam bcd_t LOAD_MD = bcd_t'(MINUTES / 10);
    localparam bcd_t LOAD_MU = bcd_t'(MINUTES % 10);

    assign zero = (minutes_d == 4'd0) && (minutes_u == 4'd0) &&
                  (seconds_d == 4'd0) && (seconds_u == 4'd0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            minutes_d <= 4'd0;
            minutes_u <= 4'd0;
            seconds_d <= 4'd0;
            seconds_u <= 4'd0;
        end else if (clear) begin
            minutes_d <= 4'd0;
            minutes_u <= 4'd0;
            seconds_d <= 4'd0;
            seconds_u <= 4'd0;
        end else if (load) begin
            minutes_d <= LOAD_MD;
            minutes_u <= LOAD_MU;
            seconds_d <= 4'd0;
            seconds_u <= 4'd0;
        end else if (dec && !zero) begin
            // Borrow ripples su -> sd -> mu -> md; md is nonzero whenever it is reached.
            if (seconds_u != 4'd0) begin
                seconds_u <= seconds_u - 4'd1;
            end else begin
                seconds_u <= 4'd9;
                if (seconds_d != 4'd0) begin
                    seconds_d <= seconds_d - 4'd1;
                end else begin
                    seconds_d <= 4'd5;
                    if (minutes_u != 4'd0) begin
                        minutes_u <= minutes_u - 4'd1;
                    end else begin
                        minutes_u <= 4'd9;
                        minutes_d <= minutes_d - 4'd1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/irrigation_scheduler.sv
// Irrigation controller FSM driving sprinkler/dripper/refill actuators with a BCD countdown.
// All outputs registered: each decision appears one clock edge after its condition holds.
module irrigation_scheduler
    import irrigation_pkg::*;
#(
    parameter int IRRIGATION_MINUTES = 30,
    parameter int SETTLE_TICKS       = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick,
    input  logic       low_water_level,
    input  logic       mid_water_level,
    input  logic       high_water_level,
    input  logic       earth_humidity,
    input  logic       air_humidity,
    input  logic       low_temperature,
    output logic       splinker_bomb,
    output logic       dripper_valvule,
    output logic       water_supply_valvule,
    output logic       alarm,
    output logic [3:0] minutes_d,
    output logic [3:0] minutes_u,
    output logic [3:0] seconds_d,
    output logic [3:0] seconds_u,
    output logic [2:0] state_code
);

    state_t     state, state_nxt;
    logic [3:0] settle_cnt, settle_nxt;
    logic       mode_spr, mode_nxt;
    logic       tmr_load, tmr_clear, tmr_dec, tmr_zero, tmr_one;
    logic       conflict;

    assign conflict = (high_water_level & ~mid_water_level) |
                      (mid_water_level & ~low_water_level);
    assign tmr_one  = (minutes_d == 4'd0) && (minutes_u == 4'd0) &&
                      (seconds_d == 4'd0) && (seconds_u == 4'd1);
    assign state_code = state;

    bcd_countdown #(.MINUTES(IRRIGATION_MINUTES)) u_timer (
        .clock     (clock),
        .reset     (reset),
        .load      (tmr_load),
        .clear     (tmr_clear),
        .dec       (tmr_dec),
        .minutes_d (minutes_d),
        .minutes_u (minutes_u),
        .seconds_d (seconds_d),
        .seconds_u (seconds_u),
        .zero      (tmr_zero)
    );

    always_comb begin
        state_nxt  = state;
        settle_nxt = settle_cnt;
        mode_nxt   = mode_spr;
        tmr_load   = 1'b0;
        tmr_clear  = 1'b0;
        tmr_dec    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (conflict)              state_nxt = ST_FAULT;
                else if (!low_water_level) state_nxt = ST_REFILL;
                else if (!earth_humidity) begin
                    state_nxt  = ST_SETTLE;
                    settle_nxt = 4'(SETTLE_TICKS);
                end
            end
            ST_SETTLE: begin
                if (conflict)              state_nxt = ST_FAULT;
                else if (!low_water_level) state_nxt = ST_REFILL;
                else if (earth_humidity)   state_nxt = ST_IDLE;
                else if (tick) begin
                    if (settle_cnt <= 4'd1) begin
                        state_nxt  = ST_IRRIGATE;
                        settle_nxt = 4'd0;
                        tmr_load   = 1'b1;
                        mode_nxt   = ~air_humidity & ~low_temperature & mid_water_level;
                    end else begin
                        settle_nxt = settle_cnt - 4'd1;
                    end
                end
            end
            ST_IRRIGATE: begin
                // Any abort clears the timer; a tick only counts when nothing outranks it.
                if (conflict) begin
                    state_nxt = ST_FAULT;
                    tmr_clear = 1'b1;
                end else if (!low_water_level) begin
                    state_nxt = ST_REFILL;
                    tmr_clear = 1'b1;
                end else if (earth_humidity) begin
                    state_nxt = ST_IDLE;
                    tmr_clear = 1'b1;
                end else if (tick) begin
                    tmr_dec = 1'b1;
                    if (tmr_one || tmr_zero) state_nxt = ST_IDLE;
                end
            end
            ST_REFILL: begin
                if (conflict)              state_nxt = ST_FAULT;
                else if (high_water_level) state_nxt = ST_IDLE;
            end
            ST_FAULT: begin
                tmr_clear = 1'b1;
                if (tick && !conflict) state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
                tmr_clear = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state                <= ST_IDLE;
            settle_cnt           <= 4'd0;
            mode_spr             <= 1'b0;
            splinker_bomb        <= 1'b0;
            dripper_valvule      <= 1'b0;
            water_supply_valvule <= 1'b0;
            alarm                <= 1'b0;
        end else begin
            state                <= state_nxt;
            settle_cnt           <= settle_nxt;
            mode_spr             <= mode_nxt;
            splinker_bomb        <= (state_nxt == ST_IRRIGATE) && mode_nxt;
            dripper_valvule      <= (state_nxt == ST_IRRIGATE) && !mode_nxt;
            water_supply_valvule <= (state_nxt == ST_REFILL);
            alarm                <= (state_nxt == ST_FAULT) || !mid_water_level;
        end
    end

endmodule

// File: tb/tb_irrigation_scheduler.sv
// Bench for irrigation_scheduler: directed scenarios plus randomized traffic against a
// seconds-based behavioural model.
module tb_irrigation_scheduler;

    localparam int MIN = 30;
    localparam int ST  = 3;

    logic       clock = 1'b0;
    logic       reset;
    logic       tick, low_w, mid_w, high_w, earth, air, cold;
    logic       spr, drp, wsv, alarm;
    logic [3:0] md, mu, sd, su;
    logic [2:0] state_code;

    int n_checks = 0;
    int n_err    = 0;

    // Model: state as integer code, remaining time as plain seconds.
    int m_state, m_secs, m_settle;
    bit m_mode, m_alarm;

    irrigation_scheduler #(.IRRIGATION_MINUTES(MIN), .SETTLE_TICKS(ST)) dut (
        .clock                (clock),
        .reset                (reset),
        .tick                 (tick),
        .low_water_level      (low_w),
        .mid_water_level      (mid_w),
        .high_water_level     (high_w),
        .earth_humidity       (earth),
        .air_humidity         (air),
        .low_temperature      (cold),
        .splinker_bomb        (spr),
        .dripper_valvule      (drp),
        .water_supply_valvule (wsv),
        .alarm                (alarm),
        .minutes_d            (md),
        .minutes_u            (mu),
        .seconds_d            (sd),
        .seconds_u            (su),
        .state_code           (state_code)
    );

    always #5 clock = ~clock;

    task automatic model_reset();
        m_state = 0; m_secs = 0; m_settle = 0; m_mode = 0; m_alarm = 0;
    endtask

    function automatic logic [22:0] exp_vec();
        logic [3:0] d3, d2, d1, d0;
        d3 = 4'(m_secs / 600);
        d2 = 4'((m_secs / 60) % 10);
        d1 = 4'((m_secs % 60) / 10);
        d0 = 4'(m_secs % 10);
        return {3'(m_state), (m_state == 2) && m_mode, (m_state == 2) && !m_mode,
                m_state == 3, m_alarm, d3, d2, d1, d0};
    endfunction

    function automatic logic [22:0] act_vec();
        return {state_code, spr, drp, wsv, alarm, md, mu, sd, su};
    endfunction

    // Drive one cycle of inputs, advance the model, then sample 1 time unit after the edge.
    task automatic step(input bit t, input bit l, input bit m, input bit h,
                        input bit e, input bit a, input bit c);
        bit conf;
        int ns;
        tick = t; low_w = l; mid_w = m; high_w = h; earth = e; air = a; cold = c;
        conf = (h && !m) || (m && !l);
        ns = m_state;
        case (m_state)
            0: if (conf) ns = 4; else if (!l) ns = 3;
               else if (!e) begin ns = 1; m_settle = ST; end
            1: if (conf) ns = 4; else if (!l) ns = 3; else if (e) ns = 0;
               else if (t) begin
                   if (m_settle == 1) begin
                       ns = 2; m_secs = MIN * 60; m_mode = !a && !c && m;
                   end else m_settle = m_settle - 1;
               end
            2: if (conf) begin ns = 4; m_secs = 0; end
               else if (!l) begin ns = 3; m_secs = 0; end
               else if (e) begin ns = 0; m_secs = 0; end
               else if (t) begin
                   m_secs = m_secs - 1;
                   if (m_secs == 0) ns = 0;
               end
            3: if (conf) ns = 4; else if (h) ns = 0;
            default: if (t && !conf) ns = 0;
        endcase
        m_state = ns;
        m_alarm = (ns == 4) || !m;
        @(posedge clock);
        #1;
    endtask

    task automatic tk(input bit t);
        step(t, low_w, mid_w, high_w, earth, air, cold);
    endtask

    task automatic test_reset();
        reset = 1'b1; tick = 0; low_w = 1; mid_w = 1; high_w = 0; earth = 1; air = 0; cold = 0;
        model_reset();
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        n_checks++;
        if (act_vec() !== 23'd0) begin
            n_err++; $display("FAIL reset_state got=%h exp=0", act_vec());
        end
        tk(1);
        n_checks++;
        if (state_code !== 3'd0) begin
            n_err++; $display("FAIL idle_wet_hold state=%0d exp=0", state_code);
        end
    endtask

    task automatic test_sprinkler_start();
        earth = 0; air = 0; cold = 0; low_w = 1; mid_w = 1; high_w = 0;
        tk(0);
        n_checks++;
        if (state_code !== 3'd1) begin
            n_err++; $display("FAIL settle_entry state=%0d exp=1", state_code);
        end
        tk(1); tk(1);
        n_checks++;
        if ({state_code, spr} !== {3'd1, 1'b0}) begin
            n_err++; $display("FAIL settle_hold state=%0d spr=%b exp=1/0", state_code, spr);
        end
        tk(1);
        n_checks++;
        if ({state_code, spr, drp, md, mu, sd, su} !== {3'd2, 1'b1, 1'b0, 16'h3000}) begin
            n_err++;
            $display("FAIL sprinkler_start state=%0d spr=%b drp=%b t=%h%h:%h%h exp=2/1/0 30:00",
                     state_code, spr, drp, md, mu, sd, su);
        end
    endtask

    task automatic test_countdown();
        for (int i = 0; i < 4000 && m_secs != 600; i++) tk(1);
        n_checks++;
        if ({md, mu, sd, su} !== 16'h1000) begin
            n_err++; $display("FAIL reach_10_00 got=%h%h:%h%h exp=10:00", md, mu, sd, su);
        end
        tk(1);
        n_checks++;
        if ({md, mu, sd, su} !== 16'h0959) begin
            n_err++; $display("FAIL borrow_09_59 got=%h%h:%h%h exp=09:59", md, mu, sd, su);
        end
        for (int i = 0; i < 4000 && m_secs != 1; i++) tk(1);
        n_checks++;
        if ({md, mu, sd, su, spr} !== {16'h0001, 1'b1}) begin
            n_err++; $display("FAIL reach_00_01 got=%h%h:%h%h spr=%b exp=00:01/1", md, mu, sd, su, spr);
        end
        tk(1);
        n_checks++;
        if ({state_code, spr, drp, md, mu, sd, su} !== {3'd0, 2'b00, 16'h0000}) begin
            n_err++;
            $display("FAIL expire_idle state=%0d spr=%b drp=%b t=%h%h:%h%h exp=0/0/0 00:00",
                     state_code, spr, drp, md, mu, sd, su);
        end
        earth = 1;
        tk(1);
        n_checks++;
        if ({state_code, spr, drp} !== {3'd0, 2'b00}) begin
            n_err++; $display("FAIL post_expire state=%0d spr=%b drp=%b exp=0/0/0", state_code, spr, drp);
        end
    endtask

    task automatic test_refill();
        earth = 0;
        tk(0); tk(1); tk(1); tk(1); tk(1); tk(1);
        low_w = 0; mid_w = 0;
        tk(1);
        n_checks++;
        if ({state_code, wsv, spr, drp, alarm, md, mu, sd, su} !== {3'd3, 4'b1001, 16'h0}) begin
            n_err++;
            $display("FAIL refill_entry state=%0d wsv=%b spr=%b alarm=%b t=%h%h:%h%h exp=3/1/0/1 00:00",
                     state_code, wsv, spr, alarm, md, mu, sd, su);
        end
        low_w = 1; mid_w = 1; high_w = 1;
        tk(0);
        n_checks++;
        if ({state_code, wsv, alarm} !== {3'd0, 2'b00}) begin
            n_err++; $display("FAIL refill_done state=%0d wsv=%b alarm=%b exp=0/0/0", state_code, wsv, alarm);
        end
        high_w = 0; earth = 1;
        tk(0);
    endtask

    task automatic test_fault();
        earth = 0;
        tk(0); tk(1);
        high_w = 1; mid_w = 0;
        tk(1);
        n_checks++;
        if ({state_code, alarm, spr, drp, wsv} !== {3'd4, 4'b1000}) begin
            n_err++; $display("FAIL fault_entry state=%0d alarm=%b act=%b%b%b exp=4/1/000",
                              state_code, alarm, spr, drp, wsv);
        end
        mid_w = 1; earth = 1;
        tk(0);
        n_checks++;
        if ({state_code, alarm} !== {3'd4, 1'b1}) begin
            n_err++; $display("FAIL fault_wait_tick state=%0d alarm=%b exp=4/1", state_code, alarm);
        end
        tk(1);
        n_checks++;
        if ({state_code, alarm} !== {3'd0, 1'b0}) begin
            n_err++; $display("FAIL fault_exit state=%0d alarm=%b exp=0/0", state_code, alarm);
        end
        high_w = 0;
        tk(0);
    endtask

    task automatic test_dripper_latch();
        earth = 0; air = 1;
        tk(0); tk(1); tk(1); tk(1);
        air = 0;
        for (int i = 0; i < 6; i++) begin
            tk(1);
            n_checks++;
            if ({state_code, drp, spr} !== {3'd2, 2'b10}) begin
                n_err++; $display("FAIL dripper_hold state=%0d drp=%b spr=%b exp=2/1/0", state_code, drp, spr);
            end
        end
        earth = 1;
        tk(1);
        n_checks++;
        if ({state_code, drp, md, mu, sd, su} !== {3'd0, 1'b0, 16'h0}) begin
            n_err++; $display("FAIL wet_abort state=%0d drp=%b t=%h%h:%h%h exp=0/0 00:00",
                              state_code, drp, md, mu, sd, su);
        end
    endtask

    task automatic test_async_reset();
        earth = 0; air = 0;
        tk(0); tk(1); tk(1); tk(1);
        for (int i = 0; i < 4000 && m_secs != 12 * 60 + 34; i++) tk(1);
        n_checks++;
        if ({md, mu, sd, su, spr} !== {16'h1234, 1'b1}) begin
            n_err++; $display("FAIL reach_12_34 got=%h%h:%h%h spr=%b exp=12:34/1", md, mu, sd, su, spr);
        end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (act_vec() !== 23'd0) begin
            n_err++; $display("FAIL async_reset got=%h exp=0", act_vec());
        end
        model_reset();
        @(posedge clock);
        #1 reset = 1'b0;
        tk(1);
        n_checks++;
        if ({state_code, spr, drp} !== {3'd1, 2'b00}) begin
            n_err++; $display("FAIL post_reset state=%0d spr=%b drp=%b exp=1/0/0", state_code, spr, drp);
        end
    endtask

    task automatic test_random();
        logic [2:0] lv;
        logic [2:0] valid [4];
        logic [2:0] bad [4];
        valid[0] = 3'b000; valid[1] = 3'b100; valid[2] = 3'b110; valid[3] = 3'b111;
        bad[0]   = 3'b010; bad[1]   = 3'b001; bad[2]   = 3'b011; bad[3]   = 3'b101;
        lv = 3'b110;
        for (int i = 0; i < 3000; i++) begin
            bit e;
            e = earth;
            if ($urandom_range(0, 19) == 0)
                lv = ($urandom_range(0, 6) == 0) ? bad[$urandom_range(0, 3)] : valid[$urandom_range(0, 3)];
            if ($urandom_range(0, 29) == 0) e = !e;
            step(1'($urandom_range(0, 1)), lv[2], lv[1], lv[0], e,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            n_checks++;
            if (act_vec() !== exp_vec()) begin
                n_err++; $display("FAIL random_cycle%0d got=%h exp=%h", i, act_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_sprinkler_start();
        test_countdown();
        test_refill();
        test_fault();
        test_dripper_latch();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/irrigation_scheduler.md
IRRIGATION_SCHEDULER -- requirements
Module: irrigation_scheduler

Interface
REQ-001 Parameter IRRIGATION_MINUTES, default 30, irrigation cycle length in minutes; legal range 1..59.
REQ-002 Parameter SETTLE_TICKS, default 3, ticks earth must stay dry before a cycle starts; legal range 1..15.
REQ-003 clock  in  1  single system clock, rising-edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 tick  in  1  one-cycle 1 Hz enable pulse.
REQ-006 low_water_level, mid_water_level, high_water_level  in  1 each  reservoir level sensors, 1 = water present.
REQ-007 earth_humidity  in  1  1 = soil wet.
REQ-008 air_humidity, low_temperature  in  1 each  1 = humid air / cold.
REQ-009 splinker_bomb, dripper_valvule, water_supply_valvule  out  1 each  actuator enables, 1 = on.
REQ-010 alarm  out  1  fault or low-reservoir warning.
REQ-011 minutes_d, minutes_u, seconds_d, seconds_u  out  4 each  BCD remaining irrigation time.
REQ-012 state_code  out  3  current FSM state: IDLE=0, SETTLE=1, IRRIGATE=2, REFILL=3, FAULT=4.

Function
REQ-013 conflict = (high & ~mid) | (mid & ~low), evaluated combinationally every cycle.
REQ-014 All outputs registered; each decision takes effect on the clock edge after its condition holds.
REQ-015 Priority within every state: conflict > ~low_water_level > earth_humidity > timer expiry.
REQ-016 IDLE: all actuators off, timer 00:00; conflict -> FAULT; else ~low -> REFILL; else ~earth_humidity -> SETTLE, settle counter loaded with SETTLE_TICKS.
REQ-017 SETTLE: counter decrements per tick; earth_humidity=1 -> IDLE; tick at counter=1 -> IRRIGATE, mode latched, timer loaded IRRIGATION_MINUTES:00.
REQ-018 Mode latch: sprinkler when ~air_humidity & ~low_temperature & mid_water_level, else dripper; held constant for the whole cycle.
REQ-019 IRRIGATE: splinker_bomb or dripper_valvule on per latched mode, never both; timer decrements one second per tick, BCD with borrow (mm:00 -> (mm-1):59).
REQ-020 IRRIGATE exit: tick at 00:01 -> timer 00:00 and IDLE on same edge; earth wet -> IDLE with timer cleared; ~low -> REFILL (cycle aborted, timer cleared).
REQ-021 REFILL: water_supply_valvule=1, irrigation actuators off; high_water_level=1 -> IDLE; conflict -> FAULT.
REQ-022 FAULT: all actuators off, alarm=1, digits show 00:00; exits to IDLE on the first tick with conflict=0.
REQ-023 alarm=1 in FAULT or whenever ~mid_water_level in any other state.
REQ-024 tick coincident with a higher-priority transition: transition wins, no timer decrement.
REQ-025 Timer never underflows below 00:00; digits always legal BCD (0..9, tens of seconds 0..5).

Reset
REQ-026 reset asserted asynchronously forces IDLE, all actuators 0, alarm 0, digits 0, settle counter 0, mode latch dripper.
REQ-027 reset mid-cycle aborts irrigation immediately; no actuator pulse after release before a fresh SETTLE completes.

Structure
REQ-028 Package irrigation_pkg holds state enum, BCD digit typedef, state_code constants.
REQ-029 Sub-module bcd_countdown (load, decrement-on-tick, zero flag, four BCD digits) instantiated once.

Verification
REQ-030 SETTLE_TICKS=3, levels 1/1/0, earth dry, air dry, warm: third tick -> IRRIGATE, splinker_bomb=1, digits 3,0,0,0.
REQ-031 Timer at 10:00, one tick -> 09:59; at 00:01, one tick -> 00:00, IDLE, actuators 0 next edge.
REQ-032 IRRIGATE, low_water_level drops -> REFILL, water_supply_valvule=1; high rises -> IDLE.
REQ-033 high=1, mid=0 in any state -> FAULT, alarm=1, actuators 0; conflict cleared then tick -> IDLE.
REQ-034 Air humid during SETTLE, dry after latch -> dripper_valvule=1 held for whole cycle.
REQ-035 reset pulse mid-IRRIGATE at 12:34 -> asynchronous IDLE, digits 00:00, actuators 0 before next clock edge.
